uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of a one-hot framing FSM.
// Latency: a word pushed into an empty FIFO while idle drives the start bit one clock later.
// Backpressure: din_ready drops while the FIFO is full; a pop on the same edge does not admit a word.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   s_tick            baud oversampling strobe (OVERSAMPLE ticks per serial bit)
//   din/din_valid/din_ready   word push handshake into the FIFO
//   parity_mode       00 none, 01 even, 10 odd, 11 none (sampled when a frame starts)
//   two_stop          0 = one stop bit, 1 = two stop bits (sampled when a frame starts)
//   tx                registered serial line, idle high
//   busy, tx_done_tick, fifo_count, state   status outputs
module uart_tx_fifo #(
    parameter int N_DATA     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            s_tick,
    input  logic [N_DATA-1:0]               din,
    input  logic                            din_valid,
    output logic                            din_ready,
    input  logic [1:0]                      parity_mode,
    input  logic                            two_stop,
    output logic                            tx,
    output logic                            busy,
    output logic                            tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [4:0]                      state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    // FIFO storage and pointers; pointers wrap naturally since the depth is a power of 2
    logic [N_DATA-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [N_DATA-1:0] head;

    // Framing state
    state_t            state_q, state_n;
    logic [TW-1:0]     tick_cnt, tick_n;
    logic [3:0]        bit_cnt, bit_n;     // data bit index, or stop bit index in STOP
    logic [N_DATA-1:0] shreg, shreg_n;
    logic              tx_n;
    logic              done_n;
    logic              par_en;             // frame configuration latched at pop
    logic              par_bit;
    logic              stop2;
    logic              last_tick;

    assign din_ready = (fifo_count < (AW+1)'(FIFO_DEPTH));
    assign push      = din_valid && din_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state_q != IDLE);
    assign state     = state_q;
    assign last_tick = s_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_comb begin
        state_n = state_q;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = tx;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_n = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    tick_n  = '0;
                    bit_n   = '0;
                    shreg_n = head;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (s_tick) tick_n = tick_cnt + 1'b1;
                if (last_tick) begin
                    tick_n  = '0;
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (s_tick) tick_n = tick_cnt + 1'b1;
                if (last_tick) begin
                    tick_n = '0;
                    if (bit_cnt == 4'(N_DATA - 1)) begin
                        bit_n = '0;
                        if (par_en) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        // shift so the next data bit sits at bit 0
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (s_tick) tick_n = tick_cnt + 1'b1;
                if (last_tick) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (s_tick) tick_n = tick_cnt + 1'b1;
                if (last_tick) begin
                    tick_n = '0;
                    if (stop2 && (bit_cnt == '0)) begin
                        bit_n = 4'd1;
                    end else begin
                        bit_n   = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                    tx_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tick_n  = '0;
                bit_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
            par_en       <= 1'b0;
            par_bit      <= 1'b0;
            stop2        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
        end else begin
            state_q      <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shreg        <= shreg_n;
            tx           <= tx_n;
            tx_done_tick <= done_n;
            if (pop) begin
                par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit <= (^head) ^ (parity_mode == 2'b10);
                stop2   <= two_stop;
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [1:0] parity_mode;
    logic       two_stop;

    // default configuration instance
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       tx, busy, tx_done_tick;
    logic [2:0] fifo_count;
    logic [4:0] state;

    // N_DATA=5, OVERSAMPLE=4 instance
    logic [4:0] din5;
    logic       din_valid5;
    logic       din_ready5;
    logic       tx5, busy5, tx_done_tick5;
    logic [2:0] fifo_count5;
    logic [4:0] state5;

    int total = 0;
    int bad   = 0;

    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h34, 8'h48, 8'h5F};

    uart_tx_fifo dut (
        .clock(clock), .reset(reset), .s_tick(s_tick), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .parity_mode(parity_mode), .two_stop(two_stop), .tx(tx),
        .busy(busy), .tx_done_tick(tx_done_tick), .fifo_count(fifo_count), .state(state)
    );

    uart_tx_fifo #(.N_DATA(5), .OVERSAMPLE(4), .FIFO_DEPTH(4)) dut5 (
        .clock(clock), .reset(reset), .s_tick(s_tick), .din(din5), .din_valid(din_valid5),
        .din_ready(din_ready5), .parity_mode(parity_mode), .two_stop(two_stop), .tx(tx5),
        .busy(busy5), .tx_done_tick(tx_done_tick5), .fifo_count(fifo_count5), .state(state5)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 1) ? tx5 : tx;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? tx_done_tick5 : tx_done_tick;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy5 : busy;
    endfunction

    // one clock, optionally with an s_tick strobe; returns 1 time unit after the edge
    task automatic tick_cycle(input logic t);
        @(negedge clock);
        s_tick = t;
        @(posedge clock);
        #1;
        s_tick = 1'b0;
    endtask

    task automatic push(input int sel, input logic [8:0] w);
        @(negedge clock);
        if (sel == 1) begin
            din5 = w[4:0];
            din_valid5 = 1'b1;
        end else begin
            din = w[7:0];
            din_valid = 1'b1;
        end
        @(posedge clock);
        #1;
        din_valid  = 1'b0;
        din_valid5 = 1'b0;
    endtask

    // Called with the start bit already on the line. fr holds the expected frame bits,
    // bit 0 first. Every tick is followed by an idle clock to check that nothing moves
    // without s_tick.
    task automatic check_frame(input string tag, input int sel, input logic [15:0] fr,
                               input int nb, input int os, input logic next_tx,
                               input logic perturb, input logic gap_push);
        int errs = 0;
        for (int k = 0; k < nb * os; k++) begin
            if (get_tx(sel) !== fr[k / os] || get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b1)
                errs++;
            if (perturb && k == os * 3) begin
                two_stop    = ~two_stop;
                parity_mode = 2'b10;
            end
            tick_cycle(1'b0);
            if (get_tx(sel) !== fr[k / os]) errs++;
            tick_cycle(1'b1);
        end
        chk({tag, "_bits"}, errs, 0);
        chk({tag, "_done"}, get_done(sel), 1);
        chk({tag, "_end_tx"}, get_tx(sel), 1);
        if (gap_push) begin
            din       = 8'hEE;
            din_valid = 1'b1;
        end
        tick_cycle(1'b0);
        din_valid = 1'b0;
        chk({tag, "_done_1clk"}, get_done(sel), 0);
        chk({tag, "_next_tx"}, get_tx(sel), next_tx);
    endtask

    initial begin
        int errs;
        reset = 1'b1;
        s_tick = 1'b0;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        din = '0;
        din_valid = 1'b0;
        din5 = '0;
        din_valid5 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", din_ready, 1);
        chk("rst_state", state, 5'b00001);
        @(negedge clock);
        reset = 1'b0;

        // 0xA5, no parity, one stop bit
        push(0, 9'h0A5);
        chk("a5_count", fifo_count, 1);
        chk("a5_idle_tx", tx, 1);
        tick_cycle(1'b0);
        chk("a5_latency_tx", tx, 0);
        chk("a5_state", state, 5'b00010);
        chk("a5_popped", fifo_count, 0);
        check_frame("a5", 0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, 1'b1, 1'b0, 1'b0);

        // even parity over 0x07 -> 1
        parity_mode = 2'b01;
        push(0, 9'h007);
        tick_cycle(1'b0);
        check_frame("par_even", 0, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 16, 1'b1, 1'b0, 1'b0);

        // odd parity over 0x07 -> 0
        parity_mode = 2'b10;
        push(0, 9'h007);
        tick_cycle(1'b0);
        check_frame("par_odd", 0, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 16, 1'b1, 1'b0, 1'b0);

        // two stop bits; configuration flipped mid-frame must not matter
        parity_mode = 2'b00;
        two_stop = 1'b1;
        push(0, 9'h000);
        tick_cycle(1'b0);
        check_frame("two_stop", 0, {5'b0, 2'b11, 8'h00, 1'b0}, 11, 16, 1'b1, 1'b1, 1'b0);
        parity_mode = 2'b00;
        two_stop = 1'b0;

        // burst of 5 into a depth-4 FIFO
        for (int i = 0; i < 5; i++) push(0, {1'b0, words[i]});
        chk("burst_count", fifo_count, 4);
        chk("burst_ready", din_ready, 0);
        chk("burst_state", state, 5'b00010);
        push(0, 9'h0EE);
        chk("full_reject", fifo_count, 4);
        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("burst%0d", i), 0, {6'b0, 1'b1, words[i], 1'b0}, 10, 16,
                        (i < 4) ? 1'b0 : 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0);
            if (i == 0) chk("full_pop_reject", fifo_count, 3);
        end
        chk("burst_empty", fifo_count, 0);

        // reset during data bit 3 with two words queued
        push(0, 9'h081);
        tick_cycle(1'b0);
        push(0, 9'h042);
        push(0, 9'h024);
        chk("mid_count", fifo_count, 2);
        repeat (72) tick_cycle(1'b1);
        chk("mid_state", state, 5'b00100);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_count", fifo_count, 0);
        chk("arst_state", state, 5'b00001);
        chk("arst_busy", busy, 0);
        chk("arst_ready", din_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            tick_cycle(1'b1);
            if (tx !== 1'b1 || tx_done_tick !== 1'b0 || state !== 5'b00001) errs++;
        end
        chk("post_rst_quiet", errs, 0);
        push(0, 9'h03C);
        tick_cycle(1'b0);
        check_frame("post_rst", 0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 16, 1'b1, 1'b0, 1'b0);

        // 5 data bits, 4 ticks per bit
        push(1, 9'h013);
        tick_cycle(1'b0);
        chk("n5_state", state5, 5'b00010);
        check_frame("n5", 1, {9'b0, 1'b1, 5'b10011, 1'b0}, 7, 4, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
